// File: rtl/serial_mod_checker.sv
// Serial divisibility checker: running residue of a framed bit stream modulo MOD, MSB- or LSB-first.
// Define MODCHK_FRAME_END_EN to add frame_end input with result_valid/result_div reporting.
module serial_mod_checker #(
    parameter int MOD       = 3,
    parameter int MSB_FIRST = 1,
    parameter int CNT_W     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic                   in_bit,
    input  logic                   frame_start,
`ifdef MODCHK_FRAME_END_EN
    input  logic                   frame_end,
    output logic                   result_valid,
    output logic                   result_div,
`endif
    output logic                   y,
    output logic [$clog2(MOD)-1:0] residue,
    output logic                   out_valid,
    output logic [CNT_W-1:0]       bit_count
);

    localparam int RW = $clog2(MOD);
    localparam logic [RW:0]      MOD_V   = (RW+1)'(MOD);
    localparam logic [RW-1:0]    W_ONE   = RW'(1'b1);
    localparam logic [RW-1:0]    R_ZERO  = {RW{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    if (MOD < 2 || MOD > 255) begin : g_bad_mod
        $error("serial_mod_checker: MOD must lie in 2..255");
    end

    // Any operand below 2*MOD folds back into range with a single subtract.
    function automatic logic [RW-1:0] cond_sub(input logic [RW:0] t);
        logic [RW:0] diff;
        diff = t - MOD_V;
        if (t >= MOD_V) begin
            cond_sub = diff[RW-1:0];
        end else begin
            cond_sub = t[RW-1:0];
        end
    endfunction

    logic [RW-1:0]    residue_q, residue_d;
    logic [RW-1:0]    weight_q, weight_d;
    logic [CNT_W-1:0] bit_count_q, bit_count_d;
    logic             y_q, y_d;
    logic             out_valid_q, out_valid_d;

    logic [RW-1:0]    base_res_s, base_w_s, fold_res_s, fold_w_s;
    logic [CNT_W-1:0] base_cnt_s;
    logic             start_s;

`ifdef MODCHK_FRAME_END_EN
    logic restart_q, restart_d;
    logic result_valid_q, result_valid_d;
    logic result_div_q, result_div_d;
    assign start_s = frame_start | restart_q;
`else
    assign start_s = frame_start;
`endif

    // Next-state: fold the consumed bit on top of either the held or the restarted state.
    always_comb begin
        base_res_s = start_s ? R_ZERO : residue_q;
        base_w_s   = start_s ? W_ONE : weight_q;
        base_cnt_s = start_s ? CNT_ZERO : bit_count_q;
        if (MSB_FIRST != 0) begin
            fold_res_s = cond_sub({base_res_s, in_bit});
        end else begin
            fold_res_s = cond_sub({1'b0, base_res_s} + (in_bit ? {1'b0, base_w_s} : {(RW+1){1'b0}}));
        end
        fold_w_s = cond_sub({base_w_s, 1'b0});

        residue_d   = residue_q;
        weight_d    = weight_q;
        bit_count_d = bit_count_q;
        y_d         = y_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            residue_d   = fold_res_s;
            weight_d    = fold_w_s;
            bit_count_d = (base_cnt_s == CNT_MAX) ? base_cnt_s : base_cnt_s + CNT_ONE;
            y_d         = (fold_res_s == R_ZERO);
            out_valid_d = 1'b1;
        end else if (start_s) begin
            residue_d   = R_ZERO;
            weight_d    = W_ONE;
            bit_count_d = CNT_ZERO;
            y_d         = 1'b0;
        end else begin
            out_valid_d = 1'b0;
        end

`ifdef MODCHK_FRAME_END_EN
        restart_d      = frame_end;
        result_valid_d = frame_end;
        if (frame_end) begin
            result_div_d = y_d;
        end else begin
            result_div_d = result_div_q;
        end
`endif
    end

    // State and output flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            residue_q      <= R_ZERO;
            weight_q       <= W_ONE;
            bit_count_q    <= CNT_ZERO;
            y_q            <= 1'b0;
            out_valid_q    <= 1'b0;
`ifdef MODCHK_FRAME_END_EN
            restart_q      <= 1'b0;
            result_valid_q <= 1'b0;
            result_div_q   <= 1'b0;
`endif
        end else begin
            residue_q      <= residue_d;
            weight_q       <= weight_d;
            bit_count_q    <= bit_count_d;
            y_q            <= y_d;
            out_valid_q    <= out_valid_d;
`ifdef MODCHK_FRAME_END_EN
            restart_q      <= restart_d;
            result_valid_q <= result_valid_d;
            result_div_q   <= result_div_d;
`endif
        end
    end

    assign y         = y_q;
    assign residue   = residue_q;
    assign out_valid = out_valid_q;
    assign bit_count = bit_count_q;
`ifdef MODCHK_FRAME_END_EN
    assign result_valid = result_valid_q;
    assign result_div   = result_div_q;
`endif

endmodule

// File: tb/tb_serial_mod_checker.sv
// Directed bench for serial_mod_checker: four instances cover MOD 3/5/7, both bit orders and a narrow counter.
module tb_serial_mod_checker;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // a: MOD=3 MSB-first; b: MOD=5 MSB-first; c: MOD=7 LSB-first; d: MOD=3 with CNT_W=2
    logic a_iv = 1'b0, a_ib = 1'b0, a_fs = 1'b0, a_fe = 1'b0;
    logic b_iv = 1'b0, b_ib = 1'b0, b_fs = 1'b0;
    logic c_iv = 1'b0, c_ib = 1'b0, c_fs = 1'b0;
    logic d_iv = 1'b0, d_ib = 1'b0, d_fs = 1'b0;

    logic       a_y, a_ov, b_y, b_ov, c_y, c_ov, d_y, d_ov;
    logic [1:0] a_res, d_res, d_cnt;
    logic [2:0] b_res, c_res;
    logic [7:0] a_cnt, b_cnt, c_cnt;
`ifdef MODCHK_FRAME_END_EN
    logic a_rv, a_rd, b_rv, b_rd, c_rv, c_rd, d_rv, d_rd;
`endif

    serial_mod_checker #(.MOD(3), .MSB_FIRST(1), .CNT_W(8)) u_a (
        .clk(clk), .reset(reset), .in_valid(a_iv), .in_bit(a_ib), .frame_start(a_fs),
`ifdef MODCHK_FRAME_END_EN
        .frame_end(a_fe), .result_valid(a_rv), .result_div(a_rd),
`endif
        .y(a_y), .residue(a_res), .out_valid(a_ov), .bit_count(a_cnt));

    serial_mod_checker #(.MOD(5), .MSB_FIRST(1), .CNT_W(8)) u_b (
        .clk(clk), .reset(reset), .in_valid(b_iv), .in_bit(b_ib), .frame_start(b_fs),
`ifdef MODCHK_FRAME_END_EN
        .frame_end(1'b0), .result_valid(b_rv), .result_div(b_rd),
`endif
        .y(b_y), .residue(b_res), .out_valid(b_ov), .bit_count(b_cnt));

    serial_mod_checker #(.MOD(7), .MSB_FIRST(0), .CNT_W(8)) u_c (
        .clk(clk), .reset(reset), .in_valid(c_iv), .in_bit(c_ib), .frame_start(c_fs),
`ifdef MODCHK_FRAME_END_EN
        .frame_end(1'b0), .result_valid(c_rv), .result_div(c_rd),
`endif
        .y(c_y), .residue(c_res), .out_valid(c_ov), .bit_count(c_cnt));

    serial_mod_checker #(.MOD(3), .MSB_FIRST(1), .CNT_W(2)) u_d (
        .clk(clk), .reset(reset), .in_valid(d_iv), .in_bit(d_ib), .frame_start(d_fs),
`ifdef MODCHK_FRAME_END_EN
        .frame_end(1'b0), .result_valid(d_rv), .result_div(d_rd),
`endif
        .y(d_y), .residue(d_res), .out_valid(d_ov), .bit_count(d_cnt));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int b_bits[8] = '{1, 1, 0, 0, 1, 1, 1, 1};
    int b_fsv[8]  = '{1, 0, 0, 0, 0, 1, 0, 0};
    int b_res_e[8] = '{1, 3, 1, 2, 0, 1, 3, 2};
    int b_cnt_e[8] = '{1, 2, 3, 4, 5, 1, 2, 3};
    int c_bits[7] = '{0, 1, 1, 1, 1, 0, 1};
    int c_fsv[7]  = '{0, 0, 0, 0, 1, 0, 0};
    int c_res_e[7] = '{0, 2, 6, 0, 1, 1, 5};
    int d_bits[5] = '{1, 0, 1, 1, 0};
    int d_res_e[5] = '{1, 2, 2, 2, 1};
    int d_cnt_e[5] = '{1, 2, 3, 3, 3};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_y", a_y, 0);
        check("rst_res", a_res, 0);
        check("rst_ov", a_ov, 0);
        check("rst_cnt", a_cnt, 0);
        check("rst_c_res", c_res, 0);
        reset = 1'b1;

        // Modulus 3, MSB-first: 1,1,0 (6)
        a_iv = 1'b1; a_ib = 1'b1; tick();
        check("m3_res1", a_res, 1); check("m3_y1", a_y, 0); check("m3_cnt1", a_cnt, 1); check("m3_ov1", a_ov, 1);
        a_ib = 1'b1; tick();
        check("m3_res2", a_res, 0); check("m3_y2", a_y, 1); check("m3_cnt2", a_cnt, 2);
        a_ib = 1'b0; tick();
        check("m3_res3", a_res, 0); check("m3_y3", a_y, 1); check("m3_cnt3", a_cnt, 3);
        a_iv = 1'b0;

        // Modulus 5, MSB-first: 25 then back-to-back frame of 7
        for (int i = 0; i < 8; i++) begin
            b_iv = 1'b1; b_ib = b_bits[i][0]; b_fs = b_fsv[i][0];
            tick();
            check($sformatf("m5_res%0d", i), b_res, b_res_e[i]);
            check($sformatf("m5_cnt%0d", i), b_cnt, b_cnt_e[i]);
            check($sformatf("m5_y%0d", i), b_y, (b_res_e[i] == 0) ? 1 : 0);
        end
        // frame_start without a bit clears the frame
        b_iv = 1'b0; b_fs = 1'b1; tick();
        check("m5_fs_res", b_res, 0); check("m5_fs_cnt", b_cnt, 0); check("m5_fs_ov", b_ov, 0); check("m5_fs_y", b_y, 0);
        b_fs = 1'b0;

        // Modulus 7, LSB-first: 14 then frame of 5
        for (int i = 0; i < 7; i++) begin
            c_iv = 1'b1; c_ib = c_bits[i][0]; c_fs = c_fsv[i][0];
            tick();
            check($sformatf("m7_res%0d", i), c_res, c_res_e[i]);
            check($sformatf("m7_y%0d", i), c_y, (c_res_e[i] == 0) ? 1 : 0);
        end
        c_iv = 1'b0; c_fs = 1'b0;

        // in_valid gaps on MOD=3: 1, idle, idle, 1
        a_iv = 1'b1; a_ib = 1'b1; a_fs = 1'b1; tick();
        check("gap_res0", a_res, 1); check("gap_cnt0", a_cnt, 1); check("gap_ov0", a_ov, 1);
        a_fs = 1'b0; a_iv = 1'b0; a_ib = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("gap_res_idle%0d", i), a_res, 1);
            check($sformatf("gap_cnt_idle%0d", i), a_cnt, 1);
            check($sformatf("gap_y_idle%0d", i), a_y, 0);
            check($sformatf("gap_ov_idle%0d", i), a_ov, 0);
        end
        a_iv = 1'b1; a_ib = 1'b1; tick();
        check("gap_res3", a_res, 0); check("gap_y3", a_y, 1); check("gap_cnt3", a_cnt, 2); check("gap_ov3", a_ov, 1);

        // Counter saturation with CNT_W=2
        for (int i = 0; i < 5; i++) begin
            d_iv = 1'b1; d_ib = d_bits[i][0];
            tick();
            check($sformatf("sat_cnt%0d", i), d_cnt, d_cnt_e[i]);
            check($sformatf("sat_res%0d", i), d_res, d_res_e[i]);
        end
        d_iv = 1'b0;

        // Asynchronous reset mid-frame at residue 2
        a_fs = 1'b1; a_ib = 1'b1; tick();
        a_fs = 1'b0; a_ib = 1'b0; tick();
        check("mid_res", a_res, 2); check("mid_ov", a_ov, 1);
        #2 reset = 1'b0;
        #1;
        check("arst_y", a_y, 0); check("arst_res", a_res, 0); check("arst_ov", a_ov, 0); check("arst_cnt", a_cnt, 0);
        a_iv = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        a_iv = 1'b1; a_ib = 1'b1; tick();
        check("post_res", a_res, 1); check("post_cnt", a_cnt, 1);
        a_iv = 1'b0;

`ifdef MODCHK_FRAME_END_EN
        // 1,1 with frame_end on the last bit, then a fresh bit
        a_iv = 1'b1; a_ib = 1'b1; a_fs = 1'b1; tick();
        a_fs = 1'b0; a_fe = 1'b1; tick();
        check("fe_rv", a_rv, 1); check("fe_rd", a_rd, 1); check("fe_y", a_y, 1);
        a_fe = 1'b0; a_ib = 1'b1; tick();
        check("fe_rv_off", a_rv, 0); check("fe_rd_hold", a_rd, 1);
        check("fe_res", a_res, 1); check("fe_cnt", a_cnt, 1);
        a_iv = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/serial_mod_checker.md
Name: serial_mod_checker

Overview:
- Serial bit-stream divisibility checker, generalised from the fixed mod-3 detector to any modulus MOD >= 2.
- Tracks the running residue of a framed serial number, MSB-first or LSB-first.
- Outputs a registered divisible flag, the residue, a valid strobe and a saturating bit count.
- Sits between serial deserialisers and control logic that needs "stream value mod N" without reassembling the word.

Parameters:
MOD, 3, modulus; legal range 2..255; elaboration error outside range
MSB_FIRST, 1, 1 = bits arrive MSB-first (Horner fold); 0 = LSB-first (weighted fold)
CNT_W, 8, width of the bit counter

Ports:
clk  input  1  single clock; all state updates on posedge
reset  input  1  asynchronous, active-low reset; asserted low, released synchronously to clk
in_valid  input  1  in_bit is consumed this cycle
in_bit  input  1  serial data bit
frame_start  input  1  start a new number; residue restarts from 0 before any bit is folded this cycle
y  output  1  registered: 1 when the residue after the last consumed bit is 0
residue  output  RW  registered current residue, RW = $clog2(MOD)
out_valid  output  1  registered: 1 for one cycle after each consumed bit
bit_count  output  CNT_W  bits consumed in the current frame; saturates at all-ones

Behaviour:
- Reset (reset low, asynchronous):
  - residue=0, weight=1, bit_count=0, y=0, out_valid=0.
  - While reset is held low, every input is ignored.
- Latency: one cycle. The bit sampled at edge k is reflected in y, residue and out_valid after edge k.
- Consume rule: a bit is folded only when in_valid=1. When in_valid=0 and frame_start=0:
  - residue, weight, bit_count and y hold.
  - out_valid=0.
- MSB_FIRST=1:
  - t = 2*residue + in_bit, computed in RW+1 bits.
  - residue' = (t >= MOD) ? t - MOD : t. One conditional subtract is sufficient because t < 2*MOD.
- MSB_FIRST=0:
  - Internal weight register w, RW bits, holds 2^n mod MOD. Reset and frame restart set w to 1.
  - residue' = residue + (in_bit ? w : 0), with one conditional subtract.
  - w' = 2w, with one conditional subtract.
  - w updates only on consumed bits.
- y' = (residue' == 0). out_valid' = 1 on every consumed bit.
- bit_count:
  - Increments on each consumed bit.
  - Saturates at 2^CNT_W - 1 and never wraps.
  - The residue keeps updating after the count saturates.
- frame_start=1 with in_valid=1:
  - The fold uses residue=0 and w=1 as the old state.
  - bit_count' = 1.
  - The new frame's first bit is included.
- frame_start=1 with in_valid=0:
  - residue=0, w=1, bit_count=0, y=0, out_valid=0.
- Back-to-back frames need no idle cycle.
- Compatibility: with MOD=3 and MSB_FIRST=1, y matches the legacy mod-3 detector cycle for cycle, given in_valid tied high and no frame_start.
- Reset mid-frame: all state is discarded immediately. The first consumed bit after release starts a fresh number; frame_start is not required.
- Internal next-state logic is combinational and latch-free. Every output is a flop.

Optional Feature:
- Macro: MODCHK_FRAME_END_EN.
- When defined:
  - Adds input frame_end (1 bit) and outputs result_valid (1 bit) and result_div (1 bit).
  - When frame_end=1 with in_valid=1, the bit is folded first. On the next cycle result_valid=1 for exactly one cycle and result_div = y for that frame.
  - result_div holds its value until the next frame_end.
  - The frame then auto-restarts: residue=0, w=1, bit_count=0, as if frame_start were applied to the following bit.
  - frame_end with in_valid=0 reports the current y and restarts the frame.
  - Reset clears result_valid and result_div to 0.
- When undefined: these ports and their logic do not exist. Behaviour is exactly as above.

Test Plan:
- MOD=3, MSB-first, stream 1,1,0 (6) -> residue 1,0,0; y 0,1,1; bit_count 1,2,3.
- MOD=5, MSB-first, frame_start with first bit, bits 1,1,0,0,1 (25) -> final residue 0, y=1; then frame_start+1,1,1 (7) -> residue 1,3,2, y=0.
- MOD=7, LSB-first, bits 0,1,1,1 (14) -> residue 0,2,6,0; y=1 after 4th bit; bits after frame_start 1,0,1 (5) -> residue 1,1,5.
- in_valid gaps: MOD=3, bits 1,idle,idle,1 (3) -> residue, y and bit_count hold across idle cycles; out_valid low on idle cycles; final y=1.
- Reset low mid-frame at residue 2 -> y=0, residue=0, out_valid=0 immediately (asynchronous); after release, bit 1 -> residue 1, bit_count=1.
- CNT_W=2, 5 consumed bits -> bit_count 1,2,3,3,3; residue still correct. With MODCHK_FRAME_END_EN, MOD=3, 1,1 plus frame_end -> result_valid pulse, result_div=1; next bit 1 -> residue 1.
